// File: rtl/sync_fifo_flags.sv
// Single-clock show-ahead FIFO with occupancy count, threshold flags and sticky error flags.
// Define SYNC_FIFO_PEAK_COUNT_EN to enable the peak_count high-water-mark register.
module sync_fifo_flags #(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          wr_en,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow,
    output logic [$clog2(FIFO_DEPTH):0]   peak_count
);

    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] FULL_COUNT   = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_COUNT  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_COUNT = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE      = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_reg;
    logic [ADDR_WIDTH:0]   rd_ptr_reg;
    logic [ADDR_WIDTH:0]   count_reg;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  overflow_reg;
    logic                  underflow_reg;
    logic                  wr_acc;
    logic                  rd_acc;

    // Level flags decode from the registered count so acceptance sees start-of-cycle state.
    assign empty        = (count_reg == '0);
    assign full         = (count_reg == FULL_COUNT);
    assign almost_full  = (count_reg >= AFULL_COUNT);
    assign almost_empty = (count_reg <= AEMPTY_COUNT);
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        count_next = count_reg;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr_reg[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // Show-ahead: the head word is visible without a read request.
    assign rd_data = mem[rd_ptr_reg[ADDR_WIDTH-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_reg <= wr_ptr_reg + CNT_ONE;
            end
            if (rd_acc) begin
                rd_ptr_reg <= rd_ptr_reg + CNT_ONE;
            end
            count_reg <= count_next;
            // A new error in the clearing cycle keeps the flag set.
            overflow_reg  <= (wr_en & full)  | (overflow_reg  & ~clr_err);
            underflow_reg <= (rd_en & empty) | (underflow_reg & ~clr_err);
        end
    end

`ifdef SYNC_FIFO_PEAK_COUNT_EN
    logic [ADDR_WIDTH:0] peak_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_reg <= '0;
        end else if (clr_err) begin
            peak_reg <= count_next;
        end else if (count_next > peak_reg) begin
            peak_reg <= count_next;
        end
    end

    assign peak_count = peak_reg;
`else
    assign peak_count = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed self-checking bench for sync_fifo_flags (default parameters: 8-bit data, depth 16).
// peak_count expectations follow SYNC_FIFO_PEAK_COUNT_EN when the bench is built with it.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
    logic [4:0] peak_count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    sync_fifo_flags #(
        .DATA_WIDTH   (8),
        .FIFO_DEPTH   (16),
        .AFULL_THRESH (12),
        .AEMPTY_THRESH(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .clr_err     (clr_err),
        .rd_data     (rd_data),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .peak_count  (peak_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, take the rising edge, sample 1 time unit later.
    task automatic cycle(input logic r, input logic we, input logic [7:0] wd,
                         input logic re, input logic ce);
        rst = r; wr_en = we; wr_data = wd; rd_en = re; clr_err = ce;
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc=%0d rst=%0b wr=%0b wd=%02h rd=%0b clr=%0b -> count=%0d rd_data=%02h ovf=%0b unf=%0b peak=%0d",
                 cyc, r, we, wd, re, ce, count, rd_data, overflow, underflow, peak_count);
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
    endtask

    function automatic logic [4:0] exp_peak(input int v);
`ifdef SYNC_FIFO_PEAK_COUNT_EN
        return 5'(v);
`else
        return 5'd0 & 5'(v);
`endif
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] nwr;
        logic [7:0] nrd;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h00;

        // Reset, then idle
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_aempty", almost_empty, 1);
        check("rst_full", full, 0);
        check("rst_afull", almost_full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);
        check("rst_peak", peak_count, 0);

        // Fill 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            cycle(0, 1, 8'(i), 0, 0);
            check("fill_count", count, i);
            check("fill_afull", almost_full, (i >= 12) ? 1 : 0);
            check("fill_full", full, (i == 16) ? 1 : 0);
            check("fill_empty", empty, 0);
        end
        check("fill_head", rd_data, 8'h01);
        check("fill_peak", peak_count, exp_peak(16));

        // Drain, checking order
        for (int i = 1; i <= 16; i++) begin
            check("drain_data", rd_data, 8'(i));
            cycle(0, 0, 0, 1, 0);
            check("drain_count", count, 16 - i);
            check("drain_aempty", almost_empty, (16 - i <= 4) ? 1 : 0);
        end
        check("drain_empty", empty, 1);
        check("drain_full", full, 0);
        check("drain_unf", underflow, 0);

        // Full + simultaneous read/write: write rejected
        for (int i = 1; i <= 16; i++) cycle(0, 1, 8'(i), 0, 0);
        check("ovf_pre_full", full, 1);
        cycle(0, 1, 8'hAA, 1, 0);
        check("ovf_count", count, 15);
        check("ovf_flag", overflow, 1);
        check("ovf_head", rd_data, 8'h02);
        for (int i = 2; i <= 16; i++) begin
            check("ovf_drain", rd_data, 8'(i));
            cycle(0, 0, 0, 1, 0);
        end
        check("ovf_drained_empty", empty, 1);
        check("ovf_hold", overflow, 1);
        cycle(0, 0, 0, 0, 1);
        check("ovf_clr", overflow, 0);

        // Empty + simultaneous read/write: read rejected
        cycle(0, 1, 8'h55, 1, 0);
        check("unf_flag", underflow, 1);
        check("unf_count", count, 1);
        check("unf_data", rd_data, 8'h55);
        check("unf_empty", empty, 0);
        check("unf_no_ovf", overflow, 0);
        cycle(0, 0, 0, 0, 1);
        check("unf_clr", underflow, 0);
        check("unf_clr_count", count, 1);
        // Clear coinciding with a new error: set wins
        cycle(0, 0, 0, 1, 0);
        check("unf_pop_empty", empty, 1);
        cycle(0, 0, 0, 1, 1);
        check("unf_set_wins", underflow, 1);
        cycle(0, 0, 0, 0, 1);
        check("unf_clr2", underflow, 0);

        // Streaming across pointer wrap at count 8
        nwr = 8'h30; nrd = 8'h30;
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, nwr, 0, 0);
            nwr++;
        end
        check("stream_fill", count, 8);
        for (int i = 0; i < 40; i++) begin
            check("stream_data", rd_data, nrd);
            cycle(0, 1, nwr, 1, 0);
            nwr++; nrd++;
            check("stream_count", count, 8);
        end
        for (int i = 0; i < 8; i++) begin
            check("stream_tail", rd_data, nrd);
            cycle(0, 0, 0, 1, 0);
            nrd++;
        end
        check("stream_empty", empty, 1);
        check("stream_errs", {overflow, underflow}, 2'b00);

        // Reset mid-operation at count 7 with an error pending and a write requested
        cycle(0, 0, 0, 1, 0);
        check("mid_unf_set", underflow, 1);
        for (int i = 0; i < 7; i++) cycle(0, 1, 8'(8'h70 + i), 0, 0);
        check("mid_pre_count", count, 7);
        cycle(1, 1, 8'hEE, 0, 0);
        check("mid_count", count, 0);
        check("mid_empty", empty, 1);
        check("mid_unf", underflow, 0);
        check("mid_ovf", overflow, 0);
        check("mid_peak", peak_count, 0);

        // High-water mark: fill to 10, drain to 2, clear
        for (int i = 0; i < 10; i++) cycle(0, 1, 8'(8'hA0 + i), 0, 0);
        check("peak_fill_count", count, 10);
        check("peak_fill_head", rd_data, 8'hA0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 0);
        check("peak_drain_count", count, 2);
        check("peak_drain_head", rd_data, 8'hA8);
        check("peak_hold", peak_count, exp_peak(10));
        cycle(0, 0, 0, 0, 1);
        check("peak_clr", peak_count, exp_peak(2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Single-clock, parametrised FIFO; next generation of the team's FIFO line for same-domain buffering between pipeline stages.
- Adds features the dual-clock FIFO lacks:
  - show-ahead (first-word fall-through) read;
  - occupancy count;
  - programmable almost-full and almost-empty thresholds;
  - sticky overflow and underflow error flags.

Parameters:
- DATA_WIDTH, 8, width of each data word.
- FIFO_DEPTH, 16, number of entries; power of 2, at least 2.
- AFULL_THRESH, 12, almost_full asserts when count >= AFULL_THRESH; legal range 1..FIFO_DEPTH.
- AEMPTY_THRESH, 4, almost_empty asserts when count <= AEMPTY_THRESH; legal range 0..FIFO_DEPTH-1.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- wr_data  input  DATA_WIDTH  write data.
- wr_en  input  1  write request.
- rd_en  input  1  read request (pops the head word).
- clr_err  input  1  clears the sticky overflow/underflow flags.
- rd_data  output  DATA_WIDTH  head word; valid whenever empty=0.
- full  output  1  count == FIFO_DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_THRESH.
- almost_empty  output  1  count <= AEMPTY_THRESH.
- count  output  ADDR_WIDTH+1  current occupancy, 0..FIFO_DEPTH; ADDR_WIDTH = $clog2(FIFO_DEPTH).
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.
- peak_count  output  ADDR_WIDTH+1  high-water mark (see Optional Feature).

Behaviour:
- Reset (rst=1 at a rising edge) has priority over every other input. It sets:
  - wr_ptr=0, rd_ptr=0, count=0;
  - overflow=0, underflow=0, peak_count=0.
  - Therefore empty=1, full=0, almost_empty=1, almost_full=0 (given AFULL_THRESH>=1).
  - Memory contents are not reset. rd_data is don't-care while empty=1.
- Reset asserted mid-operation discards all stored data. The next cycle behaves as the post-reset state.
- Acceptance:
  - wr_acc = wr_en & ~full
  - rd_acc = rd_en & ~empty
  - Both are evaluated on the flag values registered at the start of the cycle.
- Write: on wr_acc, mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data and wr_ptr increments.
- Read: on rd_acc, rd_ptr increments.
- Pointers are ADDR_WIDTH+1 bits wide and wrap naturally modulo 2*FIFO_DEPTH.
- count <= count + wr_acc - rd_acc. count is a register; all four level flags decode combinationally from it.
- Show-ahead read: rd_data = mem[rd_ptr[ADDR_WIDTH-1:0]] (combinational read).
  - A word written at edge N is on rd_data with empty=0 from edge N onward, i.e. in the cycle after the write.
  - There is no additional read latency.
- Simultaneous read and write:
  - When full: the read is accepted, the write is rejected. count goes FIFO_DEPTH-1, overflow sets.
  - When empty: the write is accepted, the read is rejected. count goes to 1, underflow sets.
  - Otherwise both are accepted, count is unchanged, and order is preserved.
- Sticky error flags:
  - overflow sets at the edge where wr_en & full.
  - underflow sets at the edge where rd_en & empty.
  - Both hold until clr_err or rst.
  - If clr_err and a new error occur in the same cycle, the flag sets (set wins).
- Rejected requests never modify the pointers, memory or count.
- The design is data-path only; no state machine beyond the pointers and counters.

Optional Feature:
- Macro: SYNC_FIFO_PEAK_COUNT_EN.
- Defined:
  - peak_count registers max(peak_count, next count) at every edge.
  - clr_err resets peak_count to the next count value.
  - rst resets peak_count to 0.
- Not defined: peak_count is tied to 0 and no tracking register is synthesised. The port list is identical in both builds.

Test Plan:
- Reset then idle 5 cycles -> count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
- Write 0x01..0x10 on 16 consecutive cycles, then read 16 consecutive cycles -> checks at each stage:
  - full=1 after the 16th edge;
  - almost_full=1 once count reaches 12;
  - rd_data sequence 0x01..0x10;
  - empty=1 after the last read;
  - almost_empty=1 once count drops to 4.
- Fill to 16, then assert wr_en=1 with wr_data=0xAA and rd_en=1 for 1 cycle -> expected:
  - count=15, overflow=1;
  - 0xAA is never read;
  - the head advances 0x01 -> 0x02.
- With the FIFO empty, assert wr_en=1 (0x55) and rd_en=1 for 1 cycle -> expected:
  - underflow=1, count=1, rd_data=0x55;
  - then pulse clr_err -> underflow=0.
- Streaming wrap-around: hold count at 8 with continuous simultaneous read/write of an incrementing pattern for 40 cycles -> count stays 8 and no data is lost or reordered across the pointer wrap.
- Reset mid-operation, plus the optional feature:
  - Reset asserted with count=7 -> next cycle count=0, empty=1, error flags cleared.
  - With SYNC_FIFO_PEAK_COUNT_EN defined, fill to 10 then drain to 2 -> peak_count=10; after clr_err -> peak_count=2.
